// File: rtl/rchdc_pkg.sv
// rtl/rchdc_pkg.sv - shared types and default sizing for the RCHDC classifier controller
package rchdc_pkg;

    localparam int SMP_SIZE = 16;
    localparam int SET_SIZE = 8;
    localparam int CLS_NUM  = 4;
    localparam int CLS_DW   = $clog2(CLS_NUM);
    localparam int SIMI_W   = 10;

    localparam logic MODE_TRAIN   = 1'b0;
    localparam logic MODE_PREDICT = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ENCODE,
        WAIT_ENC,
        WRITE,
        SCAN,
        DONE
    } ctrl_state_e;

endpackage

// File: rtl/rchdc_ctrl_if.sv
// rtl/rchdc_ctrl_if.sv - command, feature, AM, similarity and result signals of the controller
interface rchdc_ctrl_if #(
    parameter int CLS_DW = rchdc_pkg::CLS_DW,
    parameter int SIMI_W = rchdc_pkg::SIMI_W
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_mode;
    // one extra bit so out-of-range labels reach the range check instead of aliasing
    logic [CLS_DW:0]   cmd_label;
    logic              feat_valid;
    logic              feat_ready;
    logic              enc_en;
    logic              enc_clear;
    logic              enc_done;
    logic              am_we;
    logic [CLS_DW-1:0] am_waddr;
    logic [CLS_DW-1:0] am_raddr;
    logic              simi_valid;
    logic [SIMI_W-1:0] simi;
    logic              res_valid;
    logic              res_ready;
    logic [CLS_DW-1:0] res_class;
    logic [SIMI_W-1:0] res_simi;
    logic              busy;

    modport master (
        output cmd_valid, cmd_mode, cmd_label, feat_valid, enc_done,
               simi_valid, simi, res_ready,
        input  cmd_ready, feat_ready, enc_en, enc_clear, am_we, am_waddr,
               am_raddr, res_valid, res_class, res_simi, busy
    );

    modport slave (
        input  cmd_valid, cmd_mode, cmd_label, feat_valid, enc_done,
               simi_valid, simi, res_ready,
        output cmd_ready, feat_ready, enc_en, enc_clear, am_we, am_waddr,
               am_raddr, res_valid, res_class, res_simi, busy
    );

endinterface

// File: rtl/rchdc_argmax.sv
// rtl/rchdc_argmax.sv - running argmax over similarity results; ties keep the earlier index
module rchdc_argmax #(
    parameter int IDX_W   = 2,
    parameter int SCORE_W = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               valid,
    input  logic [SCORE_W-1:0] score,
    input  logic [IDX_W-1:0]   index,
    output logic [IDX_W-1:0]   best_idx,
    output logic [SCORE_W-1:0] best_score
);

    logic have;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            have       <= 1'b0;
            best_idx   <= '0;
            best_score <= '0;
        end else if (valid && (!have || score > best_score)) begin
            have       <= 1'b1;
            best_idx   <= index;
            best_score <= score;
        end
    end

endmodule

// File: rtl/rchdc_ctrl.sv
// rtl/rchdc_ctrl.sv - TRAIN/PREDICT sequencer for the RCHDC encoder, class AM and similarity units
module rchdc_ctrl
    import rchdc_pkg::*;
#(
    parameter int SMP_SIZE_P = rchdc_pkg::SMP_SIZE,
    parameter int SET_SIZE_P = rchdc_pkg::SET_SIZE,
    parameter int CLS_NUM_P  = rchdc_pkg::CLS_NUM,
    parameter int SIMI_W_P   = rchdc_pkg::SIMI_W
) (
    input  logic          clk,
    input  logic          rst,
    rchdc_ctrl_if.slave   bus
);

    localparam int CLS_DW_P = $clog2(CLS_NUM_P);
    localparam int CNT_W    = $clog2(SMP_SIZE_P * SET_SIZE_P + 1);

    localparam logic [CNT_W-1:0]  LAST_TRAIN = CNT_W'(SMP_SIZE_P * SET_SIZE_P - 1);
    localparam logic [CNT_W-1:0]  LAST_PRED  = CNT_W'(SMP_SIZE_P - 1);
    localparam logic [CLS_DW_P:0] CLS_LIM    = (CLS_DW_P + 1)'(CLS_NUM_P);
    localparam logic [CLS_DW_P:0] CLS_LAST_W = (CLS_DW_P + 1)'(CLS_NUM_P - 1);
    localparam logic [CLS_DW_P-1:0] CLS_LAST = CLS_DW_P'(CLS_NUM_P - 1);

    ctrl_state_e state, state_nxt;

    logic                  mode;
    logic [CLS_DW_P:0]     label;
    logic                  err;
    logic [CNT_W-1:0]      feat_cnt;
    logic [CLS_DW_P-1:0]   issue_cnt;
    logic [CLS_DW_P:0]     res_cnt;
    logic [CLS_DW_P-1:0]   best_idx;
    logic [SIMI_W_P-1:0]   best_score;

    logic accept, label_bad, handshake, feat_last, simi_take, simi_last;

    assign accept    = (state == IDLE) && bus.cmd_valid;
    assign label_bad = (bus.cmd_mode == MODE_TRAIN) && (bus.cmd_label >= CLS_LIM);
    assign handshake = (state == ENCODE) && bus.feat_valid;
    assign feat_last = (feat_cnt == ((mode == MODE_TRAIN) ? LAST_TRAIN : LAST_PRED));
    assign simi_take = (state == SCAN) && bus.simi_valid && (res_cnt < CLS_LIM);
    assign simi_last = simi_take && (res_cnt == CLS_LAST_W);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (accept) state_nxt = label_bad ? DONE : CLEAR;
            CLEAR:    state_nxt = ENCODE;
            ENCODE:   if (handshake && feat_last) state_nxt = WAIT_ENC;
            WAIT_ENC: if (bus.enc_done) state_nxt = (mode == MODE_PREDICT) ? SCAN : WRITE;
            WRITE:    state_nxt = DONE;
            SCAN:     if (simi_last) state_nxt = DONE;
            DONE:     if (bus.res_ready) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode      <= MODE_TRAIN;
            label     <= '0;
            err       <= 1'b0;
            feat_cnt  <= '0;
            issue_cnt <= '0;
            res_cnt   <= '0;
        end else begin
            if (accept) begin
                mode      <= bus.cmd_mode;
                label     <= bus.cmd_label;
                err       <= label_bad;
                feat_cnt  <= '0;
                issue_cnt <= '0;
                res_cnt   <= '0;
            end
            if (handshake) feat_cnt <= feat_cnt + 1'b1;
            // read address walks the classes once, then parks on the last one
            if (state == SCAN && issue_cnt != CLS_LAST) issue_cnt <= issue_cnt + 1'b1;
            if (simi_take) res_cnt <= res_cnt + 1'b1;
        end
    end

    rchdc_argmax #(
        .IDX_W   (CLS_DW_P),
        .SCORE_W (SIMI_W_P)
    ) u_argmax (
        .clk        (clk),
        .rst        (rst),
        .clear      (accept),
        .valid      (simi_take),
        .score      (bus.simi),
        .index      (res_cnt[CLS_DW_P-1:0]),
        .best_idx   (best_idx),
        .best_score (best_score)
    );

    always_comb begin
        bus.cmd_ready  = (state == IDLE);
        bus.feat_ready = (state == ENCODE);
        bus.enc_en     = handshake;
        bus.enc_clear  = (state == CLEAR);
        bus.am_we      = (state == WRITE);
        bus.am_waddr   = label[CLS_DW_P-1:0];
        bus.am_raddr   = issue_cnt;
        bus.busy       = (state != IDLE);
        bus.res_valid  = 1'b0;
        bus.res_class  = '0;
        bus.res_simi   = '0;
        if (state == DONE) begin
            bus.res_valid = 1'b1;
            if (err) begin
                bus.res_class = CLS_LAST;
                bus.res_simi  = '1;
            end else if (mode == MODE_PREDICT) begin
                bus.res_class = best_idx;
                bus.res_simi  = best_score;
            end else begin
                bus.res_class = label[CLS_DW_P-1:0];
            end
        end
    end

endmodule
